// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch front end. Issues word-aligned requests to an
//   in-order instruction memory and captures the responses, tagged with
//   their PC, into a small FIFO that feeds decode. A redirect from EX
//   empties the FIFO and restarts fetching at the new address. Responses
//   that belong to the old path are drained and dropped in FLUSH.
//
// Parameters
//   DEPTH      instruction queue entries (power of two, >= 2)
//   MAX_OUTST  maximum in-flight memory requests (1..DEPTH)
//   RESET_PC   first fetch address after reset
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   imem_req/addr/gnt           request channel (addr = current fetch PC)
//   imem_rvalid/rdata           in-order response channel
//   redirect, redirect_pc       pipeline redirect (low two bits ignored)
//   if_valid/ready/pc/inst      queue head towards decode
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] MAX_O = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W:0]   DEP_C = (CNT_W + 1)'(DEPTH);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [31:0]       fetch_pc_reg, fetch_pc_next;
    logic [CNT_W-1:0]  outst_reg, outst_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;

    logic [31:0]       q_pc   [DEPTH];
    logic [31:0]       q_inst [DEPTH];

    logic              grant;
    logic              resp;
    logic              push;
    logic              pop;
    logic [CNT_W:0]    occupancy;
    logic [31:0]       resp_pc;
    logic              unused_bits;

    assign unused_bits = &redirect_pc[1:0];

    // Outstanding requests plus queued entries can never exceed DEPTH, so
    // every response that comes back always has a free slot.
    assign occupancy = {1'b0, count_reg} + {1'b0, outst_reg};
    assign imem_req  = !reset && (state_reg == RUN) &&
                       (outst_reg < MAX_O) && (occupancy < DEP_C);
    assign imem_addr = fetch_pc_reg;

    assign grant = imem_req && imem_gnt;
    // A response with nothing in flight is a leftover from before reset.
    assign resp  = imem_rvalid && (outst_reg != '0);
    assign push  = resp && (state_reg == RUN) && !redirect;
    assign pop   = if_valid && if_ready;

    // Response-PC tracker. In RUN every in-flight request is on the current
    // path (FLUSH is only left once nothing is outstanding), and requests
    // were issued at consecutive word addresses ending at fetch_pc - 4.
    // The oldest in-flight request, which the next response answers, is
    // therefore fetch_pc - 4 * outstanding.
    assign resp_pc = fetch_pc_reg - {{(30 - CNT_W){1'b0}}, outst_reg, 2'b00};

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        outst_next    = outst_reg + CNT_W'(grant) - CNT_W'(resp);
        count_next    = count_reg + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;

        if (grant) begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
        end
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end

        // A grant in the redirect cycle is still counted in outst_next, so
        // its response is drained as stale in FLUSH.
        if (redirect) begin
            fetch_pc_next = {redirect_pc[31:2], 2'b00};
            count_next    = '0;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
        end

        if (redirect || (state_reg == FLUSH)) begin
            state_next = (outst_next != '0) ? FLUSH : RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= RUN;
            fetch_pc_reg <= RESET_PC;
            outst_reg    <= '0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            outst_reg    <= outst_next;
            count_reg    <= count_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
        end
    end

    // Queue storage carries no reset; validity is tracked by count_reg.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr_reg]   <= resp_pc;
            q_inst[wr_ptr_reg] <= imem_rdata;
        end
    end

    // Head is read straight from registered storage (no rvalid bypass) and
    // forced to zero when empty so the outputs are defined out of reset.
    assign if_valid = (count_reg != '0);
    assign if_pc    = if_valid ? q_pc[rd_ptr_reg]   : 32'h0;
    assign if_inst  = if_valid ? q_inst[rd_ptr_reg] : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int          DEPTH     = 4;
    localparam int          MAX_OUTST = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    // second instance for the address wrap case
    logic        w_reset;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_gnt;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_redirect;
    logic [31:0] w_rpc;
    logic        w_ifv;
    logic        w_ready;
    logic [31:0] w_ifpc;
    logic [31:0] w_ifinst;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst)
    );

    fetch_unit #(.DEPTH(4), .MAX_OUTST(2), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(w_reset),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .redirect(w_redirect), .redirect_pc(w_rpc),
        .if_valid(w_ifv), .if_ready(w_ready), .if_pc(w_ifpc), .if_inst(w_ifinst)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    req_t        pend_q[$];   // memory model: granted, not yet answered
    ent_t        exp_q[$];    // scoreboard: expected queue contents
    int          epoch;
    int          cyc;
    logic [31:0] exp_fetch;
    int          n_checks;
    int          n_fail;

    bit          gnt_rand;
    int          ready_pct;
    int          lat_lo;
    int          lat_hi;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock: entered and left just after a falling edge.
    task automatic step(input bit do_redir, input logic [31:0] rpc);
        int    n_out;
        int    n_stale;
        bit    exp_req;
        bit    have_resp;
        req_t  r;
        req_t  nr;
        ent_t  e;
        ent_t  ne;
        bit    g;

        n_out   = pend_q.size();
        n_stale = 0;
        foreach (pend_q[i]) if (pend_q[i].epoch != epoch) n_stale++;

        exp_req = (n_stale == 0) && (n_out < MAX_OUTST) && (exp_q.size() + n_out < DEPTH);
        n_checks++;
        if (imem_req !== exp_req) begin
            n_fail++;
            $display("FAIL imem_req cyc=%0d got=%b want=%b", cyc, imem_req, exp_req);
        end
        n_checks++;
        if (if_valid !== (exp_q.size() != 0)) begin
            n_fail++;
            $display("FAIL if_valid cyc=%0d got=%b want=%b", cyc, if_valid, exp_q.size() != 0);
        end
        n_checks++;
        if (n_out > MAX_OUTST || exp_q.size() + n_out > DEPTH) begin
            n_fail++;
            $display("FAIL occupancy cyc=%0d outstanding=%0d queued=%0d limit=%0d/%0d",
                     cyc, n_out, exp_q.size(), MAX_OUTST, DEPTH);
        end

        imem_gnt    = gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        if_ready    = ($urandom_range(1, 100) <= ready_pct);
        redirect    = do_redir;
        redirect_pc = rpc;
        have_resp   = 1'b0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc + 1) begin
            r           = pend_q.pop_front();
            have_resp   = 1'b1;
            imem_rvalid = 1'b1;
            imem_rdata  = inst_of(r.addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        g = imem_req && imem_gnt;

        if (g) begin
            n_checks++;
            if (imem_addr !== exp_fetch) begin
                n_fail++;
                $display("FAIL imem_addr cyc=%0d got=%h want=%h", cyc, imem_addr, exp_fetch);
            end
        end
        if (if_valid && if_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (if_pc !== e.pc || if_inst !== e.inst) begin
                n_fail++;
                $display("FAIL pop cyc=%0d got pc=%h inst=%h want pc=%h inst=%h",
                         cyc, if_pc, if_inst, e.pc, e.inst);
            end
        end
        if (have_resp && r.epoch == epoch && !do_redir) begin
            ne.pc   = r.addr;
            ne.inst = inst_of(r.addr);
            exp_q.push_back(ne);
        end
        if (g) begin
            nr.addr  = exp_fetch;
            nr.epoch = epoch;
            nr.due   = cyc + 1 + $urandom_range(lat_lo, lat_hi);
            pend_q.push_back(nr);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (do_redir) begin
            exp_q.delete();
            epoch++;
            exp_fetch = {rpc[31:2], 2'b00};
        end

        @(posedge clk);
        cyc++;
        @(negedge clk);
        redirect    = 1'b0;
        imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset       = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        if_ready    = 1'b0;
        #1;
        n_checks += 4;
        if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_if_valid got=%b want=0", if_valid); end
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_imem_req got=%b want=0", imem_req); end
        if (if_pc !== 32'h0)   begin n_fail++; $display("FAIL rst_if_pc got=%h want=0", if_pc); end
        if (if_inst !== 32'h0) begin n_fail++; $display("FAIL rst_if_inst got=%h want=0", if_inst); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        pend_q.delete();
        exp_q.delete();
        epoch     = 0;
        exp_fetch = RESET_PC;
        reset     = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL first_req got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
        // stray response with nothing in flight must be ignored
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        imem_rvalid = 1'b0;
        n_checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_rvalid got valid=%b req=%b want valid=0 req=1", if_valid, imem_req);
        end
        $display("reset done: first request at %h", imem_addr);
    endtask

    task automatic test_stream();
        gnt_rand = 1'b0; ready_pct = 100; lat_lo = 1; lat_hi = 1;
        step(1'b0, 32'h0);
        n_checks++;
        if (if_valid !== 1'b0) begin n_fail++; $display("FAIL stream_c1 got valid=%b want 0", if_valid); end
        step(1'b0, 32'h0);
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== RESET_PC || if_inst !== inst_of(RESET_PC)) begin
            n_fail++;
            $display("FAIL stream_c2 got valid=%b pc=%h inst=%h want 1 %h %h",
                     if_valid, if_pc, if_inst, RESET_PC, inst_of(RESET_PC));
        end
        repeat (16) step(1'b0, 32'h0);
        $display("stream done: next fetch %h, head pc %h", exp_fetch, if_pc);
    endtask

    task automatic test_stall();
        test_reset();
        gnt_rand = 1'b0; ready_pct = 0; lat_lo = 1; lat_hi = 1;
        repeat (12) step(1'b0, 32'h0);
        n_checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== RESET_PC) begin
            n_fail++;
            $display("FAIL stall_full got req=%b valid=%b pc=%h want 0 1 %h", imem_req, if_valid, if_pc, RESET_PC);
        end
        ready_pct = 100;
        repeat (20) step(1'b0, 32'h0);
        $display("stall done: resumed, next fetch %h", exp_fetch);
    endtask

    task automatic test_redirect_flush();
        test_reset();
        gnt_rand = 1'b0; ready_pct = 100; lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 10 && pend_q.size() < 2; i++) step(1'b0, 32'h0);
        n_checks++;
        if (pend_q.size() != 2) begin
            n_fail++;
            $display("FAIL flush_setup outstanding=%0d want 2", pend_q.size());
        end
        step(1'b1, 32'h0000_0100);
        n_checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_state got req=%b valid=%b want 0 0", imem_req, if_valid);
        end
        for (int i = 0; i < 20 && !if_valid; i++) step(1'b0, 32'h0);
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h100) begin
            n_fail++;
            $display("FAIL flush_first got valid=%b pc=%h want 1 00000100", if_valid, if_pc);
        end
        repeat (6) step(1'b0, 32'h0);
        $display("redirect/flush done: head pc %h", if_pc);
    endtask

    task automatic test_redirect_coincident();
        gnt_rand = 1'b0; ready_pct = 100; lat_lo = 1; lat_hi = 1;
        repeat (6) step(1'b0, 32'h0);
        n_checks++;
        if (!(if_valid && pend_q.size() > 0 && pend_q[0].due <= cyc + 1)) begin
            n_fail++;
            $display("FAIL coinc_setup got valid=%b outstanding=%0d want valid=1 with due response",
                     if_valid, pend_q.size());
        end
        step(1'b1, 32'h0000_0203);
        n_checks++;
        if (if_valid !== 1'b0) begin n_fail++; $display("FAIL coinc_empty got valid=%b want 0", if_valid); end
        for (int i = 0; i < 10 && !imem_req; i++) step(1'b0, 32'h0);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL coinc_restart got req=%b addr=%h want 1 00000200", imem_req, imem_addr);
        end
        for (int i = 0; i < 10 && !if_valid; i++) step(1'b0, 32'h0);
        n_checks++;
        if (if_pc !== 32'h200 || if_inst !== inst_of(32'h200)) begin
            n_fail++;
            $display("FAIL coinc_head got pc=%h inst=%h want 00000200 %h", if_pc, if_inst, inst_of(32'h200));
        end
        $display("coincident redirect done: head pc %h", if_pc);
    endtask

    task automatic test_random();
        gnt_rand = 1'b1; ready_pct = 70; lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 3)
                step(1'b1, $urandom);
            else
                step(1'b0, 32'h0);
        end
        $display("random done: %0d checks so far, next fetch %h", n_checks, exp_fetch);
    endtask

    task automatic test_wrap();
        logic [31:0] wexp [3];
        logic        prev_g;
        wexp[0] = 32'hFFFF_FFF8;
        wexp[1] = 32'hFFFF_FFFC;
        wexp[2] = 32'h0000_0000;
        @(negedge clk);
        w_reset  = 1'b0;
        w_gnt    = 1'b1;
        w_ready  = 1'b1;
        prev_g   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w_rvalid = prev_g;
            w_rdata  = 32'h1111_0000 + i;
            #1;
            n_checks++;
            if (w_req !== 1'b1 || w_addr !== wexp[i]) begin
                n_fail++;
                $display("FAIL wrap_addr%0d got req=%b addr=%h want 1 %h", i, w_req, w_addr, wexp[i]);
            end
            prev_g = w_req && w_gnt;
            @(posedge clk);
            @(negedge clk);
        end
        w_rvalid = 1'b0;
        w_gnt    = 1'b0;
        $display("wrap done: last address %h", w_addr);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; epoch = 0; exp_fetch = RESET_PC;
        gnt_rand = 1'b0; ready_pct = 100; lat_lo = 1; lat_hi = 1;
        reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
        w_reset = 1'b1; w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0;
        w_redirect = 1'b0; w_rpc = 32'h0; w_ready = 1'b0;

        test_reset();
        test_stream();
        test_stall();
        test_redirect_flush();
        test_redirect_coincident();
        test_random();
        test_reset();
        test_stream();
        test_wrap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-002 SHALL have parameter MAX_OUTST, default 2, max in-flight imem requests (1..DEPTH).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 SHALL use one clock; reset is asynchronous and active-high. Ports: clk and reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 imem_req  output  1  fetch request valid.
REQ-008 imem_addr  output  32  fetch address, word aligned.
REQ-009 imem_gnt  input  1  request accepted this cycle when imem_req=1.
REQ-010 imem_rvalid  input  1  read data valid; responses return in request order, >=1 cycle after grant.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 redirect  input  1  pipeline redirect (taken branch/jump from EX).
REQ-013 redirect_pc  input  32  new fetch address; bits [1:0] ignored.
REQ-014 if_valid  output  1  queue head holds valid instruction.
REQ-015 if_ready  input  1  decode accepts head this cycle.
REQ-016 if_pc  output  32  PC of head instruction.
REQ-017 if_inst  output  32  head instruction word.

Function
REQ-018 fetch_pc SHALL advance by 4 on each grant (imem_req && imem_gnt); imem_addr = fetch_pc, 32-bit wrap from 32'hFFFF_FFFC to 0.
REQ-019 imem_req SHALL be 1 only in state RUN when outstanding < MAX_OUTST and (count + outstanding) < DEPTH.
REQ-020 outstanding counter SHALL +1 on grant, -1 on imem_rvalid, both in same cycle -> unchanged.
REQ-021 In RUN, imem_rvalid SHALL write {pc, rdata} into queue tail at the clock edge; PC taken from a response-PC tracker in issue order.
REQ-022 Queue output registered: if_valid rises the cycle after the rvalid cycle (no bypass); if_valid = (count != 0).
REQ-023 Pop on if_valid && if_ready; push and pop in same cycle -> count unchanged; queue never overflows (guaranteed by REQ-019).
REQ-024 if_pc/if_inst SHALL be stable while if_valid && !if_ready.
REQ-025 States: RUN, FLUSH. On redirect: queue emptied, fetch_pc <= {redirect_pc[31:2],2'b00}; next state FLUSH if post-edge outstanding > 0, else RUN.
REQ-026 FLUSH: no requests issued, every rvalid discarded; transition to RUN on the edge where outstanding reaches 0.
REQ-027 Redirect in same cycle as grant: granted request counted as stale (discarded); as rvalid: data discarded; as pop: the pop is a completed handshake.
REQ-028 Redirect while in FLUSH: fetch_pc updated, stays FLUSH until drained.
REQ-029 imem_rvalid with outstanding == 0 SHALL be ignored (no state change).

Reset
REQ-030 While reset=1: state RUN, fetch_pc=RESET_PC, count=0, outstanding=0, if_valid=0, imem_req=0, if_pc=0, if_inst=0.
REQ-031 Reset mid-operation SHALL discard queue and in-flight tracking immediately; responses arriving after release with outstanding=0 ignored per REQ-029.
REQ-032 First request (addr RESET_PC) SHALL be asserted in the first cycle after reset deassertion.

Verification
REQ-033 Reset release, gnt=1, 1-cycle memory, if_ready=1 -> imem_addr 0,4,8... each cycle; if_valid from cycle 2, if_pc 0,4,8 with matching data.
REQ-034 if_ready=0 held -> exactly DEPTH(4) entries captured, imem_req drops, head stays pc=0; release -> stream resumes in order, no loss/duplication.
REQ-035 Redirect to 32'h100 with 2 outstanding -> FLUSH, both responses discarded, first new request addr 32'h100, next if_pc 32'h100.
REQ-036 Redirect_pc=32'h203 coincident with rvalid and pop -> rvalid data dropped, fetch restarts at 32'h200.
REQ-037 gnt random 50%, rvalid latency random 1-4 -> output PC sequence strictly +4, outstanding never > MAX_OUTST, count+outstanding never > DEPTH.
REQ-038 RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
